// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - 640x480@60 raster timing defaults and per-axis decode type
package vga_timing_pkg;

  localparam int H_ACTIVE_DEFAULT = 640;
  localparam int H_FRONT_DEFAULT  = 16;
  localparam int H_SYNC_DEFAULT   = 96;
  localparam int H_BACK_DEFAULT   = 48;
  localparam int H_TOTAL = H_ACTIVE_DEFAULT + H_FRONT_DEFAULT + H_SYNC_DEFAULT + H_BACK_DEFAULT;

  localparam int V_ACTIVE_DEFAULT = 480;
  localparam int V_FRONT_DEFAULT  = 10;
  localparam int V_SYNC_DEFAULT   = 2;
  localparam int V_BACK_DEFAULT   = 33;
  localparam int V_TOTAL = V_ACTIVE_DEFAULT + V_FRONT_DEFAULT + V_SYNC_DEFAULT + V_BACK_DEFAULT;

  localparam int CLK_DIV_DEFAULT = 4;

  // last marks the final active position of the axis, not the final count
  typedef struct packed {
    logic visible;
    logic sync;
    logic last;
  } axis_state_t;

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis: wrapping counter plus active/sync decode of its next value
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL  = H_TOTAL,
  parameter int ACTIVE = H_ACTIVE_DEFAULT,
  parameter int FRONT  = H_FRONT_DEFAULT,
  parameter int SYNC   = H_SYNC_DEFAULT,
  parameter int CW     = $clog2(TOTAL)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          advance_i,
  output logic [CW-1:0] cnt_next_o,
  output axis_state_t   state_next_o,
  output logic          wrap_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          at_end;

  assign at_end = (cnt_q == CW'(TOTAL - 1));
  assign wrap_o = advance_i && at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (advance_i) begin
      cnt_d = at_end ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Decode the value being loaded so the parent can register outputs in step with the count
  assign cnt_next_o           = cnt_d;
  assign state_next_o.visible = (cnt_d < CW'(ACTIVE));
  assign state_next_o.sync    = (cnt_d >= CW'(ACTIVE + FRONT)) && (cnt_d < CW'(ACTIVE + FRONT + SYNC));
  assign state_next_o.last    = (cnt_d == CW'(ACTIVE - 1));

endmodule

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - raster timing generator: pixel strobe, positions, frame count, sync pins
// Define VGA_RGB_BLANK_EN for blanked RGB outputs, with syncs delayed one pixel to match them.
module vga_timing
  import vga_timing_pkg::*;
#(
  parameter int SCREEN_WIDTH  = H_ACTIVE_DEFAULT,
  parameter int SCREEN_HEIGHT = V_ACTIVE_DEFAULT,
  parameter int H_FRONT       = H_FRONT_DEFAULT,
  parameter int H_SYNC        = H_SYNC_DEFAULT,
  parameter int H_BACK        = H_BACK_DEFAULT,
  parameter int V_FRONT       = V_FRONT_DEFAULT,
  parameter int V_SYNC        = V_SYNC_DEFAULT,
  parameter int V_BACK        = V_BACK_DEFAULT,
  parameter int CLK_DIV       = CLK_DIV_DEFAULT,
  parameter bit SYNC_POL      = 1'b0
) (
  input  logic                             clk,
  input  logic                             rst,
`ifdef VGA_RGB_BLANK_EN
  input  logic [3:0]                       r_in,
  input  logic [3:0]                       g_in,
  input  logic [3:0]                       b_in,
  output logic [3:0]                       vga_r,
  output logic [3:0]                       vga_g,
  output logic [3:0]                       vga_b,
`endif
  output logic                             pixel_en,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  position_x,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] position_y,
  output logic [$clog2(SCREEN_WIDTH)-1:0]  position_x_next,
  output logic [$clog2(SCREEN_HEIGHT)-1:0] position_y_next,
  output logic [31:0]                      frame,
  output logic                             visible,
  output logic                             hsync,
  output logic                             vsync
);

  localparam int H_TOT = SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT = SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK;
  localparam int XW    = $clog2(SCREEN_WIDTH);
  localparam int YW    = $clog2(SCREEN_HEIGHT);
  localparam int HCW   = $clog2(H_TOT);
  localparam int VCW   = $clog2(V_TOT);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q;
  logic             tick;
  logic [HCW-1:0]   h_next;
  logic [VCW-1:0]   v_next;
  axis_state_t      h_st;
  axis_state_t      v_st;
  logic             h_wrap;
  logic             v_wrap;

  // The raster, pixel_en and every registered output all move on the same edge
  assign tick = (div_q == DIV_W'(CLK_DIV - 1));

  vga_axis_counter #(
    .TOTAL (H_TOT),
    .ACTIVE(SCREEN_WIDTH),
    .FRONT (H_FRONT),
    .SYNC  (H_SYNC)
  ) u_h_counter (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (tick),
    .cnt_next_o  (h_next),
    .state_next_o(h_st),
    .wrap_o      (h_wrap)
  );

  vga_axis_counter #(
    .TOTAL (V_TOT),
    .ACTIVE(SCREEN_HEIGHT),
    .FRONT (V_FRONT),
    .SYNC  (V_SYNC)
  ) u_v_counter (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (h_wrap),
    .cnt_next_o  (v_next),
    .state_next_o(v_st),
    .wrap_o      (v_wrap)
  );

  logic          visible_d;
  logic [XW-1:0] pos_x_d, next_x_d;
  logic [YW-1:0] pos_y_d, next_y_d;

  // Next visible pixel in raster order; blanking reports the pixel it is heading to
  always_comb begin
    visible_d = h_st.visible && v_st.visible;
    next_x_d  = '0;
    next_y_d  = '0;
    if (visible_d && !h_st.last) begin
      next_x_d = XW'(h_next) + XW'(1);
      next_y_d = YW'(v_next);
    end else if (v_st.visible && !v_st.last) begin
      next_y_d = YW'(v_next) + YW'(1);
    end
    pos_x_d = visible_d ? XW'(h_next) : next_x_d;
    pos_y_d = visible_d ? YW'(v_next) : next_y_d;
  end

  logic          pixel_en_q;
  logic [XW-1:0] pos_x_q, next_x_q;
  logic [YW-1:0] pos_y_q, next_y_q;
  logic [31:0]   frame_q;
  logic          visible_q;
  logic          hsync_q;
  logic          vsync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q      <= '0;
      pixel_en_q <= 1'b0;
      pos_x_q    <= '0;
      pos_y_q    <= '0;
      next_x_q   <= XW'(1);
      next_y_q   <= '0;
      frame_q    <= '0;
      visible_q  <= 1'b1;
      hsync_q    <= ~SYNC_POL;
      vsync_q    <= ~SYNC_POL;
    end else begin
      div_q      <= tick ? '0 : div_q + DIV_W'(1);
      pixel_en_q <= tick;
      if (tick) begin
        pos_x_q   <= pos_x_d;
        pos_y_q   <= pos_y_d;
        next_x_q  <= next_x_d;
        next_y_q  <= next_y_d;
        visible_q <= visible_d;
        hsync_q   <= h_st.sync ? SYNC_POL : ~SYNC_POL;
        vsync_q   <= v_st.sync ? SYNC_POL : ~SYNC_POL;
        if (v_wrap) begin
          frame_q <= frame_q + 32'd1;
        end
      end
    end
  end

  assign pixel_en        = pixel_en_q;
  assign position_x      = pos_x_q;
  assign position_y      = pos_y_q;
  assign position_x_next = next_x_q;
  assign position_y_next = next_y_q;
  assign frame           = frame_q;
  assign visible         = visible_q;

`ifdef VGA_RGB_BLANK_EN
  logic [3:0] r_q, g_q, b_q;
  logic       hsync_dly_q, vsync_dly_q;

  // Colour arrives one pixel behind the position it was computed for, so syncs lag to match
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q         <= '0;
      g_q         <= '0;
      b_q         <= '0;
      hsync_dly_q <= ~SYNC_POL;
      vsync_dly_q <= ~SYNC_POL;
    end else if (tick) begin
      r_q         <= visible_q ? r_in : 4'h0;
      g_q         <= visible_q ? g_in : 4'h0;
      b_q         <= visible_q ? b_in : 4'h0;
      hsync_dly_q <= hsync_q;
      vsync_dly_q <= vsync_q;
    end
  end

  assign vga_r = r_q;
  assign vga_g = g_q;
  assign vga_b = b_q;
  assign hsync = hsync_dly_q;
  assign vsync = vsync_dly_q;
`else
  assign hsync = hsync_q;
  assign vsync = vsync_q;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb/tb_vga_timing.sv - self-checking bench for vga_timing on a reduced raster (VGA_RGB_BLANK_EN optional)
`timescale 1ns/1ps
module tb_vga_timing;

  localparam int W = 8, H = 4, HF = 2, HS = 3, HB = 2, VF = 1, VS = 2, VB = 1;
  localparam int HT = W + HF + HS + HB;
  localparam int VT = H + VF + VS + VB;
  localparam int FP = HT * VT;

  typedef struct packed {
    logic [31:0] pe, x, y, nx, ny, frame, vis, hs, vs, rgb, hpin, vpin;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic armed = 1'b0;
  int   t_cnt = 0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  always @(posedge clk) t_cnt <= rst ? 0 : t_cnt + 1;

  logic        a_pe, a_vis, a_hs, a_vs, b_pe, b_vis, b_hs, b_vs;
  logic [2:0]  a_x, a_nx, b_x, b_nx;
  logic [1:0]  a_y, a_ny, b_y, b_ny;
  logic [31:0] a_frame, b_frame;
`ifdef VGA_RGB_BLANK_EN
  logic [3:0] rgb_in = 4'hF;
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b;
`endif

  vga_timing #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(4), .SYNC_POL(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst),
`ifdef VGA_RGB_BLANK_EN
    .r_in(rgb_in), .g_in(rgb_in), .b_in(rgb_in), .vga_r(a_r), .vga_g(a_g), .vga_b(a_b),
`endif
    .pixel_en(a_pe), .position_x(a_x), .position_y(a_y),
    .position_x_next(a_nx), .position_y_next(a_ny), .frame(a_frame),
    .visible(a_vis), .hsync(a_hs), .vsync(a_vs)
  );

  vga_timing #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB), .CLK_DIV(1), .SYNC_POL(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst),
`ifdef VGA_RGB_BLANK_EN
    .r_in(rgb_in), .g_in(rgb_in), .b_in(rgb_in), .vga_r(b_r), .vga_g(b_g), .vga_b(b_b),
`endif
    .pixel_en(b_pe), .position_x(b_x), .position_y(b_y),
    .position_x_next(b_nx), .position_y_next(b_ny), .frame(b_frame),
    .visible(b_vis), .hsync(b_hs), .vsync(b_vs)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0d: got %0h expected %0h", name, t_cnt, act, exp);
    end
  endtask

  function automatic bit vis_at(input int pix);
    return ((pix % HT) < W) && ((pix / HT) < H);
  endfunction

  function automatic logic [31:0] lvl(input bit active, input bit pol);
    return active ? 32'(pol) : 32'(!pol);
  endfunction

  function automatic bit hs_at(input int pix);
    return ((pix % HT) >= W + HF) && ((pix % HT) < W + HF + HS);
  endfunction

  function automatic bit vs_at(input int pix);
    return ((pix / HT) >= H + VF) && ((pix / HT) < H + VF + VS);
  endfunction

  // Outputs as a function of clocks since reset release: one pixel per div clocks
  function automatic obs_t model(input int t, input int div, input bit pol);
    obs_t e;
    int   p, pix, q, pp;
    bit   found;
    p       = t / div;
    pix     = p % FP;
    e       = '0;
    e.frame = 32'(p / FP);
    e.pe    = (t >= 1 && (t % div) == 0) ? 32'd1 : 32'd0;
    e.vis   = vis_at(pix) ? 32'd1 : 32'd0;
    e.hs    = lvl(hs_at(pix), pol);
    e.vs    = lvl(vs_at(pix), pol);
    found   = 1'b0;
    for (int k = 1; k <= FP; k++) begin
      q = (pix + k) % FP;
      if (!found && vis_at(q)) begin
        found = 1'b1;
        e.nx  = 32'(q % HT);
        e.ny  = 32'(q / HT);
      end
    end
    e.x = e.vis[0] ? 32'(pix % HT) : e.nx;
    e.y = e.vis[0] ? 32'(pix / HT) : e.ny;
    if (p >= 1) begin
      pp     = (p - 1) % FP;
      e.rgb  = vis_at(pp) ? 32'hFFF : 32'h0;
      e.hpin = lvl(hs_at(pp), pol);
      e.vpin = lvl(vs_at(pp), pol);
    end else begin
      e.rgb  = 32'h0;
      e.hpin = 32'(!pol);
      e.vpin = 32'(!pol);
    end
    return e;
  endfunction

  task automatic cmp_all(input string tag, input obs_t a, input obs_t e);
    chk({tag, "_pixel_en"}, a.pe, e.pe);
    chk({tag, "_pos_x"}, a.x, e.x);
    chk({tag, "_pos_y"}, a.y, e.y);
    chk({tag, "_next_x"}, a.nx, e.nx);
    chk({tag, "_next_y"}, a.ny, e.ny);
    chk({tag, "_frame"}, a.frame, e.frame);
    chk({tag, "_visible"}, a.vis, e.vis);
`ifdef VGA_RGB_BLANK_EN
    chk({tag, "_hsync_pin"}, a.hs, e.hpin);
    chk({tag, "_vsync_pin"}, a.vs, e.vpin);
    chk({tag, "_rgb"}, a.rgb, e.rgb);
`else
    chk({tag, "_hsync"}, a.hs, e.hs);
    chk({tag, "_vsync"}, a.vs, e.vs);
`endif
  endtask

  obs_t act_a, act_b;

  always_comb begin
    act_a       = '0;
    act_a.pe    = 32'(a_pe);
    act_a.x     = 32'(a_x);
    act_a.y     = 32'(a_y);
    act_a.nx    = 32'(a_nx);
    act_a.ny    = 32'(a_ny);
    act_a.frame = a_frame;
    act_a.vis   = 32'(a_vis);
    act_a.hs    = 32'(a_hs);
    act_a.vs    = 32'(a_vs);
    act_b       = '0;
    act_b.pe    = 32'(b_pe);
    act_b.x     = 32'(b_x);
    act_b.y     = 32'(b_y);
    act_b.nx    = 32'(b_nx);
    act_b.ny    = 32'(b_ny);
    act_b.frame = b_frame;
    act_b.vis   = 32'(b_vis);
    act_b.hs    = 32'(b_hs);
    act_b.vs    = 32'(b_vs);
`ifdef VGA_RGB_BLANK_EN
    act_a.rgb   = 32'({a_r, a_g, a_b});
    act_b.rgb   = 32'({b_r, b_g, b_b});
`endif
  end

  always @(negedge clk) begin
    if (armed) begin
      cmp_all("a", act_a, model(t_cnt, 4, 1'b0));
      cmp_all("b", act_b, model(t_cnt, 1, 1'b1));
      case (t_cnt)
        3:   begin chk("lit_a_pe_t3", 32'(a_pe), 32'd0); chk("lit_a_x_t3", 32'(a_x), 32'd0); end
        4:   begin chk("lit_a_pe_t4", 32'(a_pe), 32'd1); chk("lit_a_x_t4", 32'(a_x), 32'd1);
                   chk("lit_a_nx_t4", 32'(a_nx), 32'd2); end
        8:   chk("lit_a_pe_t8", 32'(a_pe), 32'd1);
        32:  begin chk("lit_a_vis_hblank", 32'(a_vis), 32'd0); chk("lit_a_x_hblank", 32'(a_x), 32'd0);
                   chk("lit_a_y_hblank", 32'(a_y), 32'd1); end
        300: begin chk("lit_a_vis_vblank", 32'(a_vis), 32'd0); chk("lit_a_y_vblank", 32'(a_y), 32'd0); end
        479: chk("lit_a_frame_t479", a_frame, 32'd0);
        480: begin chk("lit_a_frame_t480", a_frame, 32'd1); chk("lit_a_vis_t480", 32'(a_vis), 32'd1); end
        119: chk("lit_b_frame_t119", b_frame, 32'd0);
        120: chk("lit_b_frame_t120", b_frame, 32'd1);
        default: ;
      endcase
      if (t_cnt == 1) chk("lit_b_pe_t1", 32'(b_pe), 32'd1);
`ifndef VGA_RGB_BLANK_EN
      if (t_cnt == 39) chk("lit_a_hs_h9", 32'(a_hs), 32'd1);
      if (t_cnt == 40) chk("lit_a_hs_h10", 32'(a_hs), 32'd0);
      if (t_cnt == 51) chk("lit_a_hs_h12", 32'(a_hs), 32'd0);
      if (t_cnt == 52) chk("lit_a_hs_h13", 32'(a_hs), 32'd1);
      if (t_cnt == 299) chk("lit_a_vs_v4", 32'(a_vs), 32'd1);
      if (t_cnt == 300) chk("lit_a_vs_v5", 32'(a_vs), 32'd0);
      if (t_cnt == 10) chk("lit_b_hs_h10", 32'(b_hs), 32'd1);
`else
      if (t_cnt == 32) chk("lit_a_rgb_t32", 32'({a_r, a_g, a_b}), 32'hFFF);
      if (t_cnt == 36) chk("lit_a_rgb_t36", 32'({a_r, a_g, a_b}), 32'h0);
`endif
    end
  end

  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1 armed = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (1100) @(posedge clk);
    #1;
    chk("lit_a_x_before_rst", 32'(a_x), 32'd5);
    chk("lit_a_y_before_rst", 32'(a_y), 32'd2);
    chk("lit_a_frame_before_rst", a_frame, 32'd2);
    chk("lit_b_frame_before_rst", b_frame, 32'd9);
    chk("lit_b_x_before_rst", 32'(b_x), 32'd5);
    chk("lit_b_y_before_rst", 32'(b_y), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("lit_a_pe_after_rst", 32'(a_pe), 32'd0);
    chk("lit_a_x_after_rst", 32'(a_x), 32'd0);
    chk("lit_a_nx_after_rst", 32'(a_nx), 32'd1);
    chk("lit_a_frame_after_rst", a_frame, 32'd0);
    chk("lit_a_vis_after_rst", 32'(a_vis), 32'd1);
    chk("lit_a_hs_after_rst", 32'(a_hs), 32'd1);
    chk("lit_b_hs_after_rst", 32'(b_hs), 32'd0);
    chk("lit_b_frame_after_rst", b_frame, 32'd0);
    rst = 1'b0;
    repeat (600) @(posedge clk);
    #2;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
